// File: rtl/ov7670_pixel_capture_if.sv
// Pixel stream from the OV7670 capture block to its consumer.
// Valid/ready handshake carrying one assembled pixel plus frame/line tags.
interface ov7670_pixel_capture_if #(
    parameter int PIX_W = 16
) ();
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_sof;
    logic             m_eol;

    modport master (output m_valid, output m_data, output m_sof, output m_eol, input m_ready);
    modport slave  (input m_valid, input m_data, input m_sof, input m_eol, output m_ready);
endinterface

// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel bus capture: oversampled in clk, pixels assembled, decimated,
// buffered in a first-word-fall-through FIFO and emitted with sof/eol tags.
module ov7670_pixel_capture #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_ACTIVE        = 320,
    parameter int V_ACTIVE        = 240,
    parameter int DECIM           = 1,
    parameter int FIFO_DEPTH      = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              vsync,
    input  logic                              href,
    input  logic                              pclk,
    input  logic [7:0]                        cam_data,
    input  logic                              status_clr,
    ov7670_pixel_capture_if.master            m_axis,
    output logic                              frame_start,
    output logic [15:0]                       frame_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow,
    output logic                              line_err
);
    localparam int PIX_W = 8 * BYTES_PER_PIXEL;
    localparam int ENT_W = PIX_W + 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_PIXEL - 1);
    localparam logic [COL_W-1:0] H_LIM     = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_LIM     = ROW_W'(V_ACTIVE);
    localparam logic [COL_W-1:0] EOL_COL   = COL_W'(H_ACTIVE - DECIM);
    localparam logic [COL_W-1:0] COL_MASK  = COL_W'(DECIM - 1);
    localparam logic [ROW_W-1:0] ROW_MASK  = ROW_W'(DECIM - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic       pclk;
        logic [7:0] data;
    } cam_t;

    // Input synchroniser and edge-detect history
    cam_t sync_q [SYNC_STAGES];
    cam_t sync_d [SYNC_STAGES];
    cam_t cam_s;
    logic pclk_prev_q, href_prev_q, vsync_prev_q;

    // Registered bus events
    logic       strobe_q, strobe_d;
    logic [7:0] byte_q, byte_d;
    logic       href_fall_q, href_fall_d;
    logic       vsync_rise_q, vsync_rise_d;
    logic       href_b_q, href_b_d;

    // Pixel assembly state
    logic             capture_en_q, capture_en_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PIX_W-1:0] shift_q, shift_d;
    logic [PIX_W-1:0] pix_next;
    logic             sof_arm_q, sof_arm_d;
    logic             keep;
    logic             push_q, push_d;
    logic [ENT_W-1:0] push_ent_q, push_ent_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             line_err_set;

    // FIFO and status
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] last_q, last_d, head;
    logic             full, pop, wr_en, overflow_set;
    logic             overflow_q, overflow_d, line_err_q, line_err_d;

    assign cam_s = sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb assigns defaults first so no path leaves a signal unassigned (no latches).
    always_comb begin
        sync_d[0] = '{vsync: vsync, href: href, pclk: pclk, data: cam_data};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        strobe_d     = cam_s.pclk & ~pclk_prev_q & cam_s.href & ~cam_s.vsync;
        byte_d       = cam_s.data;
        href_fall_d  = ~cam_s.href & href_prev_q;
        vsync_rise_d = cam_s.vsync & ~vsync_prev_q;
        href_b_d     = cam_s.href;
    end

    always_comb begin
        pix_next = shift_q;
        for (int b = 0; b < BYTES_PER_PIXEL; b++) begin
            if (byte_idx_q == IDX_W'(b)) pix_next[PIX_W-1-8*b -: 8] = byte_q;
        end
        keep = ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0) &&
               (col_q < H_LIM) && (row_q < V_LIM);
    end

    // Frame/line bookkeeping; a vsync rise re-arms capture and wins over a coincident href fall.
    always_comb begin
        capture_en_d  = capture_en_q;
        byte_idx_d    = byte_idx_q;
        col_d         = col_q;
        row_d         = row_q;
        shift_d       = shift_q;
        sof_arm_d     = sof_arm_q;
        push_d        = 1'b0;
        push_ent_d    = push_ent_q;
        frame_count_d = frame_count_q;
        line_err_set  = 1'b0;
        if (vsync_rise_q) begin
            line_err_set = href_b_q || (byte_idx_q != '0);
            if (capture_en_q) frame_count_d = frame_count_q + 16'd1;
            capture_en_d = 1'b1;
            byte_idx_d   = '0;
            col_d        = '0;
            row_d        = '0;
            sof_arm_d    = 1'b1;
        end else if (capture_en_q) begin
            if (href_fall_q) begin
                line_err_set = (byte_idx_q != '0);
                byte_idx_d   = '0;
                col_d        = '0;
                if (row_q != V_LIM) row_d = row_q + ROW_W'(1);
            end else if (strobe_q) begin
                shift_d = pix_next;
                if (byte_idx_q == LAST_IDX) begin
                    byte_idx_d = '0;
                    if (keep) begin
                        push_d     = 1'b1;
                        push_ent_d = {sof_arm_q, (col_q == EOL_COL), pix_next};
                        sof_arm_d  = 1'b0;
                    end
                    if (col_q != H_LIM) col_d = col_q + COL_W'(1);
                end else begin
                    byte_idx_d = byte_idx_q + IDX_W'(1);
                end
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        m_axis.m_valid = (count_q != '0);
        full           = (count_q == FULL_LVL);
        pop            = m_axis.m_valid & m_axis.m_ready;
        wr_en          = push_q & (~full | pop);
        overflow_set   = push_q & full & ~pop;
        wr_ptr_d       = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        last_d     = pop ? mem_q[rd_ptr_q] : last_q;
        head       = m_axis.m_valid ? mem_q[rd_ptr_q] : last_q;
        overflow_d = (overflow_q & ~status_clr) | overflow_set;
        line_err_d = (line_err_q & ~status_clr) | line_err_set;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            pclk_prev_q   <= 1'b0;
            href_prev_q   <= 1'b0;
            vsync_prev_q  <= 1'b0;
            strobe_q      <= 1'b0;
            byte_q        <= '0;
            href_fall_q   <= 1'b0;
            vsync_rise_q  <= 1'b0;
            href_b_q      <= 1'b0;
            capture_en_q  <= 1'b0;
            byte_idx_q    <= '0;
            col_q         <= '0;
            row_q         <= '0;
            shift_q       <= '0;
            sof_arm_q     <= 1'b0;
            push_q        <= 1'b0;
            push_ent_q    <= '0;
            frame_count_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_q        <= '0;
            overflow_q    <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            pclk_prev_q   <= cam_s.pclk;
            href_prev_q   <= cam_s.href;
            vsync_prev_q  <= cam_s.vsync;
            strobe_q      <= strobe_d;
            byte_q        <= byte_d;
            href_fall_q   <= href_fall_d;
            vsync_rise_q  <= vsync_rise_d;
            href_b_q      <= href_b_d;
            capture_en_q  <= capture_en_d;
            byte_idx_q    <= byte_idx_d;
            col_q         <= col_d;
            row_q         <= row_d;
            shift_q       <= shift_d;
            sof_arm_q     <= sof_arm_d;
            push_q        <= push_d;
            push_ent_q    <= push_ent_d;
            frame_count_q <= frame_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_q        <= last_d;
            overflow_q    <= overflow_d;
            line_err_q    <= line_err_d;
        end
    end

    // NOTE: storage has no reset; entries are only read once the pointers say they were written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_ent_q;
    end

    assign m_axis.m_data = head[PIX_W-1:0];
    assign m_axis.m_eol  = head[PIX_W];
    assign m_axis.m_sof  = head[PIX_W+1];
    assign frame_start   = vsync_rise_q;
    assign frame_count   = frame_count_q;
    assign fifo_level    = count_q;
    assign overflow      = overflow_q;
    assign line_err      = line_err_q;
endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench: two instances (full rate and 2x decimated) share one camera bus;
// popped pixels are logged per instance and compared against hand-computed values.
module tb_ov7670_pixel_capture;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync, href, pclk, status_clr;
    logic [7:0] cam_data;
    logic       ready_main, ready_dec;

    logic        fs_main, fs_dec, ov_main, ov_dec, le_main, le_dec;
    logic [15:0] fc_main, fc_dec;
    logic [4:0]  lvl_main, lvl_dec;

    ov7670_pixel_capture_if #(.PIX_W(16)) s_if ();
    ov7670_pixel_capture_if #(.PIX_W(16)) d_if ();

    assign s_if.m_ready = ready_main;
    assign d_if.m_ready = ready_dec;

    ov7670_pixel_capture #(
        .BYTES_PER_PIXEL(2), .H_ACTIVE(4), .V_ACTIVE(8), .DECIM(1),
        .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(rst_n), .vsync(vsync), .href(href), .pclk(pclk),
        .cam_data(cam_data), .status_clr(status_clr), .m_axis(s_if),
        .frame_start(fs_main), .frame_count(fc_main), .fifo_level(lvl_main),
        .overflow(ov_main), .line_err(le_main)
    );

    ov7670_pixel_capture #(
        .BYTES_PER_PIXEL(2), .H_ACTIVE(4), .V_ACTIVE(2), .DECIM(2),
        .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut_d (
        .clk(clk), .reset(rst_n), .vsync(vsync), .href(href), .pclk(pclk),
        .cam_data(cam_data), .status_clr(status_clr), .m_axis(d_if),
        .frame_start(fs_dec), .frame_count(fc_dec), .fifo_level(lvl_dec),
        .overflow(ov_dec), .line_err(le_dec)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Popped entries {sof, eol, data}, logged where the handshake is stable
    logic [17:0] q_main[$];
    logic [17:0] q_dec[$];
    int          fs_hi   = 0;
    int          fs_rise = 0;
    logic        fs_prev = 1'b0;

    always @(negedge clk) begin
        if (s_if.m_valid && s_if.m_ready) q_main.push_back({s_if.m_sof, s_if.m_eol, s_if.m_data});
        if (d_if.m_valid && d_if.m_ready) q_dec.push_back({d_if.m_sof, d_if.m_eol, d_if.m_data});
        if (fs_main) fs_hi++;
        if (fs_main && !fs_prev) fs_rise++;
        fs_prev = fs_main;
    end

    function automatic logic [17:0] qm(input int i);
        return (i < q_main.size()) ? q_main[i] : 18'h3ffff;
    endfunction

    function automatic logic [17:0] qd(input int i);
        return (i < q_dec.size()) ? q_dec[i] : 18'h3ffff;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        pclk     = 1'b0;
        tick(2);
        pclk = 1'b1;
        tick(2);
    endtask

    task automatic send_pixel(input logic [15:0] v);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    task automatic send_line(input logic [15:0] base, input int n);
        href = 1'b1;
        tick(2);
        for (int i = 0; i < n; i++) send_pixel(base + 16'(i));
        href = 1'b0;
        pclk = 1'b0;
        tick(4);
    endtask

    task automatic frame_pulse();
        vsync = 1'b1;
        tick(4);
        vsync = 1'b0;
        tick(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int bm, bd, n;
        logic [15:0] t2_pix [4];
        t2_pix[0] = 16'h1234; t2_pix[1] = 16'h5678; t2_pix[2] = 16'h9abc; t2_pix[3] = 16'hdef0;

        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; pclk = 1'b0; cam_data = '0;
        status_clr = 1'b0; ready_main = 1'b0; ready_dec = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        @(negedge clk);
        check("rst_valid", s_if.m_valid, 0);
        check("rst_level", lvl_main, 0);
        check("rst_fcount", fc_main, 0);
        check("rst_flags", {ov_main, le_main, fs_main}, 0);

        // Reset mid-line with three pixels buffered
        frame_pulse();
        frame_pulse();
        href = 1'b1; tick(2); send_byte(8'h77); href = 1'b0; pclk = 1'b0; tick(4);
        href = 1'b1; tick(2);
        send_pixel(16'h0101); send_pixel(16'h0202); send_pixel(16'h0303);
        send_byte(8'h44);
        tick(6);
        @(negedge clk);
        check("t1_pre_level", lvl_main, 3);
        check("t1_pre_fcount", fc_main, 1);
        check("t1_pre_lerr", le_main, 1);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        check("t1_valid", s_if.m_valid, 0);
        check("t1_level", lvl_main, 0);
        check("t1_fcount", fc_main, 0);
        check("t1_flags", {ov_main, le_main}, 0);
        rst_n = 1'b1;
        tick(1);
        send_byte(8'h55);
        send_pixel(16'h0606);
        href = 1'b0; pclk = 1'b0;
        tick(10);
        @(negedge clk);
        check("t1_discard_level", lvl_main, 0);
        check("t1_discard_lerr", le_main, 0);

        // Basic 2-byte assembly, one 4-pixel line
        ready_main = 1'b1;
        bm = q_main.size(); bd = q_dec.size();
        tick(1);
        frame_pulse();
        href = 1'b1; tick(2);
        for (int i = 0; i < 4; i++) send_pixel(t2_pix[i]);
        href = 1'b0; pclk = 1'b0;
        tick(12);
        @(negedge clk);
        check("t2_fcount_first", fc_main, 0);
        check("t2_count", q_main.size() - bm, 4);
        check("t2_px0", qm(bm),     {2'b10, 16'h1234});
        check("t2_px1", qm(bm + 1), {2'b00, 16'h5678});
        check("t2_px2", qm(bm + 2), {2'b00, 16'h9abc});
        check("t2_px3", qm(bm + 3), {2'b01, 16'hdef0});
        check("t2_dec_count", q_dec.size() - bd, 2);
        check("t2_dec0", qd(bd),     {2'b10, 16'h1234});
        check("t2_dec1", qd(bd + 1), {2'b01, 16'h9abc});

        // Decimation by 2 on a 4x2 frame, pixel = 16*row+col
        bm = q_main.size(); bd = q_dec.size();
        tick(1);
        frame_pulse();
        send_line(16'h0000, 4);
        send_line(16'h0010, 4);
        tick(12);
        @(negedge clk);
        check("t3_dec_count", q_dec.size() - bd, 2);
        check("t3_dec0", qd(bd),     {2'b10, 16'h0000});
        check("t3_dec1", qd(bd + 1), {2'b01, 16'h0002});
        check("t3_main_count", q_main.size() - bm, 8);
        check("t3_fcount", fc_main, 1);

        // Fill to overflow with m_ready low, latency on the first pixel
        ready_main = 1'b0;
        bm = q_main.size();
        tick(1);
        frame_pulse();
        href = 1'b1; tick(2);
        send_byte(8'h00);
        cam_data = 8'h00; pclk = 1'b0; tick(2);
        pclk = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (s_if.m_valid) break;
        end
        check("t4_latency", n, 5);
        tick(2);
        for (int i = 1; i < 4; i++) send_pixel(16'(i));
        href = 1'b0; pclk = 1'b0; tick(4);
        send_line(16'd4, 4);
        send_line(16'd8, 4);
        send_line(16'd12, 4);
        send_line(16'd16, 1);
        tick(10);
        @(negedge clk);
        check("t4_level", lvl_main, 16);
        check("t4_overflow", ov_main, 1);
        check("t4_no_pop", q_main.size() - bm, 0);
        ready_main = 1'b1;
        tick(30);
        @(negedge clk);
        check("t4_drain_count", q_main.size() - bm, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_drain%0d", i), qm(bm + i),
                  {(i == 0), (i % 4 == 3), 16'(i)});
        end
        check("t4_level_empty", lvl_main, 0);
        check("t4_hold_data", s_if.m_data, 16'd15);
        tick(1);
        status_clr = 1'b1; tick(1); status_clr = 1'b0;
        @(negedge clk);
        check("t4_ovf_clr", ov_main, 0);

        // Line ending mid-pixel
        bm = q_main.size();
        tick(1);
        frame_pulse();
        href = 1'b1; tick(2);
        send_byte(8'hab);
        href = 1'b0; pclk = 1'b0;
        tick(8);
        @(negedge clk);
        check("t5_lerr", le_main, 1);
        check("t5_no_push", q_main.size() - bm, 0);
        tick(1);
        send_line(16'hc0de, 2);
        tick(12);
        @(negedge clk);
        check("t5_clean_count", q_main.size() - bm, 2);
        check("t5_clean0", qm(bm),     {2'b10, 16'hc0de});
        check("t5_clean1", qm(bm + 1), {2'b00, 16'hc0df});
        check("t5_lerr_sticky", le_main, 1);
        tick(1);
        status_clr = 1'b1; tick(1); status_clr = 1'b0;
        @(negedge clk);
        check("t5_lerr_clr", le_main, 0);

        // frame_start pulses and frame_count wrap
        tick(1);
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
        bm = fs_hi; bd = fs_rise;
        frame_pulse(); frame_pulse(); frame_pulse();
        tick(4);
        @(negedge clk);
        check("t6_fs_rises", fs_rise - bd, 3);
        check("t6_fs_cycles", fs_hi - bm, 3);
        check("t6_fcount", fc_main, 2);
        tick(1);
        force dut.frame_count_q = 16'hffff;
        tick(2);
        release dut.frame_count_q;
        tick(1);
        frame_pulse();
        tick(4);
        @(negedge clk);
        check("t6_fcount_wrap", fc_main, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
